// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared core constants, fetch FSM state type and helpers
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DRAIN
    } fetch_state_t;

    // Instruction fetches are word aligned; low address bits are dropped.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_reg.sv
// rtl/pc_reg.sv - program counter with reset value, redirect load and +4 step
module pc_reg
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_en,
    input  logic [XLEN-1:0] load_addr,
    input  logic            inc_en,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    // Redirect wins over sequential advance.
    always_comb begin
        pc_d = pc_q;
        if (load_en) begin
            pc_d = load_addr;
        end else if (inc_en) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc       = pc_q;
    assign pc_plus4 = pc_q + 32'd4;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: single-outstanding imem handshake, buffer, redirect
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stallF,
    input  logic                       pcsrcE,
    input  logic [riscv_pkg::XLEN-1:0] pctargetE,
    output logic                       imem_req,
    output logic [riscv_pkg::XLEN-1:0] imem_addr,
    input  logic                       imem_gnt,
    input  logic                       imem_rvalid,
    input  logic [riscv_pkg::XLEN-1:0] imem_rdata,
    output logic [riscv_pkg::XLEN-1:0] instrF,
    output logic [riscv_pkg::XLEN-1:0] pcF,
    output logic [riscv_pkg::XLEN-1:0] pcplus4F,
    output logic                       validF
);

    import riscv_pkg::*;

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] ibuf_q, ibuf_d;
    logic            pc_inc;

    always_comb begin
        state_d = state_q;
        ibuf_d  = ibuf_q;
        pc_inc  = 1'b0;
        if (pcsrcE) begin
            // A granted-but-unanswered request leaves a stale response to drain.
            case (state_q)
                S_REQ:   state_d = imem_gnt    ? S_DRAIN : S_REQ;
                S_WAIT:  state_d = imem_rvalid ? S_REQ   : S_DRAIN;
                S_HOLD:  state_d = S_REQ;
                S_DRAIN: state_d = imem_rvalid ? S_REQ   : S_DRAIN;
            endcase
        end else begin
            case (state_q)
                S_REQ: begin
                    if (imem_gnt) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        ibuf_d  = imem_rdata;
                        state_d = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!stallF) begin
                        pc_inc  = 1'b1;
                        state_d = S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (imem_rvalid) state_d = S_REQ;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_REQ;
            ibuf_q  <= NOP_INSTR;
        end else begin
            state_q <= state_d;
            ibuf_q  <= ibuf_d;
        end
    end

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk       (clk),
        .reset     (reset),
        .load_en   (pcsrcE),
        .load_addr (align_word(pctargetE)),
        .inc_en    (pc_inc),
        .pc        (pcF),
        .pc_plus4  (pcplus4F)
    );

    // Gated by reset so nothing leaks out before the registered reset lands.
    assign imem_req  = (state_q == S_REQ) && !reset;
    assign validF    = (state_q == S_HOLD) && !reset;
    assign instrF    = validF ? ibuf_q : NOP_INSTR;
    assign imem_addr = pcF;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined RISC-V core, directly upstream of the fetch/decode pipeline register. It owns the program counter, issues one instruction-memory request at a time over a request/grant/response handshake, and buffers the returned word. It presents `instrF`/`pcF`/`pcplus4F` to the F/D register, injecting a NOP bubble whenever no fetched instruction is ready. Branch/jump redirects from Execute are honoured immediately, and any in-flight stale response is discarded.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC loaded on reset.
- `NOP_INSTR`, default `32'h0000_0013` (`addi x0,x0,0`): bubble presented when not valid.

Ports:
- `clk`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `stallF`  in  1: hazard unit hold. The hazard unit drives it equal to the F/D register's stall.
- `pcsrcE`  in  1: redirect request from Execute.
- `pctargetE`  in  32: redirect target.
- `imem_req`  out  1: fetch request valid.
- `imem_addr`  out  32: fetch address; always equals `pcF`.
- `imem_gnt`  in  1: request accepted this cycle.
- `imem_rvalid`  in  1: response valid.
- `imem_rdata`  in  32: response instruction.
- `instrF`  out  32: instruction to F/D; `NOP_INSTR` when `validF`=0.
- `pcF`  out  32: PC of the presented or in-flight instruction.
- `pcplus4F`  out  32: `pcF + 4`.
- `validF`  out  1: `instrF` holds a real fetched instruction.

## Operation
- States:
  - `S_REQ`: request pending.
  - `S_WAIT`: granted, awaiting data.
  - `S_HOLD`: instruction buffered.
  - `S_DRAIN`: stale response outstanding.
- Combinational outputs:
  - `imem_req` = (state==`S_REQ`) && !`reset`.
  - `validF` = (state==`S_HOLD`).
  - `instrF` = `validF` ? `ibuf` : `NOP_INSTR`.
- Transitions without redirect (`pcsrcE`=0):
  - `S_REQ`: `imem_gnt`=1 → `S_WAIT`; else stay.
  - `S_WAIT`: `imem_rvalid`=1 → capture `imem_rdata` into `ibuf`, go to `S_HOLD`; else stay.
  - `S_HOLD`: `stallF`=0 → instruction consumed; `pcF` <= `pcF`+4, go to `S_REQ`. `stallF`=1 → hold all state.
  - `S_DRAIN`: `imem_rvalid`=1 → drop data, go to `S_REQ`; else stay.
- Redirect (`pcsrcE`=1) takes priority over `stallF`. `pcF` <= {`pctargetE[31:2]`, 2'b00}, then by current state:
  - `S_REQ` with `imem_gnt`=1 → `S_DRAIN`.
  - `S_REQ` with `imem_gnt`=0 → stay in `S_REQ`.
  - `S_WAIT` with `imem_rvalid`=0 → `S_DRAIN`.
  - `S_WAIT` with `imem_rvalid`=1 → drop data, go to `S_REQ`.
  - `S_HOLD` → `S_REQ`; the buffer is discarded.
  - `S_DRAIN` with `imem_rvalid`=0 → stay in `S_DRAIN`, target updated.
  - `S_DRAIN` with `imem_rvalid`=1 → `S_REQ`.
- `imem_rvalid` is ignored in `S_REQ` and `S_HOLD`.
- `imem_gnt` is ignored outside `S_REQ`.
- Arithmetic: `pcplus4F` = `pcF` + 32'd4, modulo 2^32; `32'hFFFF_FFFC` → `32'h0000_0000`.
- When `validF`=0 and `stallF`=0, the downstream register loads the NOP bubble. This is intended behaviour.

## Timing
- Reset (registered):
  - state = `S_REQ`, `pcF` = `RESET_PC`, `ibuf` = `NOP_INSTR`.
  - While `reset`=1: `imem_req`=0, `validF`=0, `instrF`=`NOP_INSTR`.
  - First request is in the cycle after reset deasserts.
- Reset mid-operation: aborts any outstanding transaction without drain; the memory is reset concurrently.
- Memory contract:
  - At most one outstanding request.
  - `imem_rvalid` arrives no earlier than the cycle after `imem_gnt`.
  - Zero or more wait cycles are allowed on both grant and response.
- Latency with zero-wait memory and no stall: request cycle, response cycle, present cycle. Peak throughput is one instruction per 3 cycles.
- `pcF` is stable from request through presentation. It changes only on consume or redirect.

## Structure
- Shared package `riscv_pkg`:
  - `NOP_INSTR` constant.
  - `fetch_state_t` enum (`S_REQ`, `S_WAIT`, `S_HOLD`, `S_DRAIN`).
  - `XLEN`=32.
- One natural sub-module, `pc_reg`: PC register with reset-to-`RESET_PC`, redirect load, and +4 increment.
- FSM and instruction buffer stay in `fetch_stage`.

## Test plan
- Reset release, memory returns `32'h00500093` one cycle after grant, `stallF`=0 → `validF`=1 in cycle 3 with `pcF`=0, `pcplus4F`=4; next request `imem_addr`=4.
- `stallF`=1 for 4 cycles in `S_HOLD` → `instrF`/`pcF` held, `imem_req`=0; release → `pcF`=4.
- Redirect to `32'h0000_0100` while in `S_WAIT`, stale `rvalid` 2 cycles later carrying `32'hDEADBEEF` → data dropped, `validF` never 1 for it, next `imem_addr`=`32'h100`.
- Redirect and `rvalid` in same `S_WAIT` cycle → no drain, `S_REQ` next cycle with new target; redirect with `stallF`=1 in `S_HOLD` → redirect wins.
- Grant delayed 3 cycles, `pctargetE`=`32'h0000_0203` → `imem_req` held with stable addr; target aligned to `32'h200`.
- `pcF`=`32'hFFFF_FFFC` consumed → `pcplus4F`=0, next fetch at `32'h0`; reset asserted in `S_WAIT` → `S_REQ`, `pcF`=`RESET_PC`.
